// File: rtl/memory_responder_if.sv
// Datapath <-> memory responder bus: request (Read/Write/MARaddr/MDRdata) and response (Mdatain/MemDone/MemBusy/BusErr).
interface memory_responder_if;
    logic        Read;
    logic        Write;
    logic [31:0] MARaddr;
    logic [31:0] MDRdata;
    logic [31:0] Mdatain;
    logic        MemDone;
    logic        MemBusy;
    logic        BusErr;

    modport master (
        output Read, Write, MARaddr, MDRdata,
        input  Mdatain, MemDone, MemBusy, BusErr
    );

    modport slave (
        input  Read, Write, MARaddr, MDRdata,
        output Mdatain, MemDone, MemBusy, BusErr
    );
endinterface

// File: rtl/memory_responder.sv
// Single-port word memory serving one read/write at a time after WAIT_STATES wait cycles.
// Optional out-of-range detection (BusErr) is compiled in by defining MEM_RANGECHK_EN.
module memory_responder #(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH_LOG2  = 9
) (
    input  logic              Clock,
    input  logic              Clear,
    memory_responder_if.slave bus
);
    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_read_q, is_read_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic                  acc_read;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;

    assign accept = (state_q == S_IDLE) && (bus.Read || bus.Write);

    // With zero wait states the access happens on the accepting edge, so it uses the live bus.
    assign acc_addr  = (state_q == S_IDLE) ? bus.MARaddr : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? bus.MDRdata : wdata_q;
    assign acc_read  = (state_q == S_IDLE) ? bus.Read    : is_read_q;
    assign idx       = acc_addr[DEPTH_LOG2-1:0];

    assign enter_resp = ((state_q == S_WAIT) && (cnt_q == 4'd0)) ||
                        (accept && (WAIT_STATES == 0));

`ifdef MEM_RANGECHK_EN
    assign in_range = ((acc_addr >> DEPTH_LOG2) == 32'd0);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[31:DEPTH_LOG2];
    assign in_range       = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d    = bus.MARaddr;
                    wdata_d   = bus.MDRdata;
                    is_read_d = bus.Read;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rdata_d = rdata_q;
        if (enter_resp && acc_read) begin
            rdata_d = in_range ? mem[idx] : 32'h0;
        end
        done_d = enter_resp;
        err_d  = enter_resp && !in_range;
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Contents survive reset; a write abandoned by reset never reaches this commit point.
    always_ff @(posedge Clock) begin
        if (Clear && enter_resp && !acc_read && in_range) begin
            mem[idx] <= acc_wdata;
        end
    end

    assign bus.Mdatain = rdata_q;
    assign bus.MemDone = done_q;
    assign bus.MemBusy = (state_q != S_IDLE);
    assign bus.BusErr  = err_q;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: three responders (0, 1 and 2 wait states) sharing clock and reset.
module tb_memory_responder;
    logic clk;
    logic Clear;
    int   checks;
    int   failures;

    memory_responder_if b0 ();
    memory_responder_if b1 ();
    memory_responder_if b2 ();

    memory_responder #(.WAIT_STATES(0), .DEPTH_LOG2(9)) u_w0 (.Clock(clk), .Clear(Clear), .bus(b0));
    memory_responder #(.WAIT_STATES(1), .DEPTH_LOG2(9)) u_w1 (.Clock(clk), .Clear(Clear), .bus(b1));
    memory_responder #(.WAIT_STATES(2), .DEPTH_LOG2(9)) u_w2 (.Clock(clk), .Clear(Clear), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_mdat;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        case (w)
            0:       begin b0.Read = rd; b0.Write = wr; b0.MARaddr = a; b0.MDRdata = d; end
            1:       begin b1.Read = rd; b1.Write = wr; b1.MARaddr = a; b1.MDRdata = d; end
            default: begin b2.Read = rd; b2.Write = wr; b2.MARaddr = a; b2.MDRdata = d; end
        endcase
    endtask

    function automatic logic done_of(input int w);
        return (w == 0) ? b0.MemDone : (w == 1) ? b1.MemDone : b2.MemDone;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? b0.MemBusy : (w == 1) ? b1.MemBusy : b2.MemBusy;
    endfunction

    function automatic logic err_of(input int w);
        return (w == 0) ? b0.BusErr : (w == 1) ? b1.BusErr : b2.BusErr;
    endfunction

    function automatic logic [31:0] mdat_of(input int w);
        return (w == 0) ? b0.Mdatain : (w == 1) ? b1.Mdatain : b2.Mdatain;
    endfunction

    // One request held for a single accepting edge; expects MemDone exactly w cycles later.
    task automatic do_req(input int w, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input string nm,
                          input logic [31:0] exp_mdat, input logic exp_err);
        int lat;
        drive(w, rd, wr, a, d);
        @(posedge clk); #1;
        drive(w, 1'b0, 1'b0, a, d);
        lat = 0;
        while (!done_of(w) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_lat"},  32'(lat), 32'(w));
        check({nm, "_mdat"}, mdat_of(w), exp_mdat);
        check({nm, "_err"},  {31'b0, err_of(w)}, {31'b0, exp_err});
        check({nm, "_busy"}, {31'b0, busy_of(w)}, 32'd1);
        @(posedge clk); #1;
        check({nm, "_idle"}, {30'b0, done_of(w), busy_of(w)}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_done;
        logic [9:0] exp_busy;
        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b0, 1'b1, 32'h10,  32'h28918000, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'h28918000, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h30,  32'h18,       32'h28918000, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h30,  32'hFFFFFFFF, 32'h18,       1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h30,  32'h0,        32'h18,       1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h0,   32'hCAFE0001, 32'h18,       1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h1FF, 32'h12345678, 32'h18,       1'b0};
`ifdef MEM_RANGECHK_EN
        vecs[7] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h0,        1'b1};
`else
        vecs[7] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'hCAFE0001, 1'b0};
`endif
        vecs[8] = '{1'b1, 1'b0, 32'h1FF, 32'h0,        32'h12345678, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 32'h20,  32'h55,       32'h12345678, 1'b0};

        Clear = 1'b0;
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        // A request present while reset is asserted must not be taken.
        drive(2, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        check("rst_busy",  {31'b0, b2.MemBusy}, 32'd0);
        check("rst_done",  {31'b0, b2.MemDone}, 32'd0);
        check("rst_err",   {31'b0, b2.BusErr},  32'd0);
        check("rst_mdat",  b2.Mdatain, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        Clear = 1'b1;
        @(posedge clk); #1;
        check("rst_rel_busy", {31'b0, b2.MemBusy}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_req(2, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   $sformatf("w2_v%0d", i), vecs[i].exp_mdat, vecs[i].exp_err);
        end

        do_req(0, 1'b0, 1'b1, 32'h12, 32'h14, "w0_wr", 32'h0,  1'b0);
        do_req(0, 1'b1, 1'b0, 32'h12, 32'h0,  "w0_rd", 32'h14, 1'b0);

        do_req(1, 1'b0, 1'b1, 32'h5, 32'h77, "w1_wr", 32'h0, 1'b0);
        exp_done = 10'b0010010010;
        exp_busy = 10'b0011011011;
        drive(1, 1'b1, 1'b0, 32'h5, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("w1_held_done_c%0d", c), {31'b0, b1.MemDone}, {31'b0, exp_done[c-1]});
            check($sformatf("w1_held_busy_c%0d", c), {31'b0, b1.MemBusy}, {31'b0, exp_busy[c-1]});
            if (c == 8) check("w1_held_mdat", b1.Mdatain, 32'h77);
            if (c == 7) drive(1, 1'b0, 1'b0, 32'h5, 32'h0);
        end

        // Reset during WAIT of a write: outputs clear and the write is dropped.
        drive(2, 1'b0, 1'b1, 32'h20, 32'hAA);
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b0, 32'h20, 32'hAA);
        check("abort_busy_wait", {31'b0, b2.MemBusy}, 32'd1);
        Clear = 1'b0;
        @(posedge clk); #1;
        check("abort_mdat", b2.Mdatain, 32'h0);
        check("abort_flags", {29'b0, b2.MemDone, b2.MemBusy, b2.BusErr}, 32'd0);
        Clear = 1'b1;
        @(posedge clk); #1;
        do_req(2, 1'b1, 1'b0, 32'h20, 32'h0, "abort_rd", 32'h55, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'h10, 32'h0, "retain_rd", 32'h28918000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2: number of wait cycles inserted before each response; legal range 0..15.
REQ-002 Parameter DEPTH_LOG2, default 9: log2 of the number of 32-bit words; default depth is 512 words.
REQ-003 Clock  in  1: single clock; all state changes on its rising edge.
REQ-004 Clear  in  1: reset; synchronous and active-low.
REQ-005 Read  in  1: read request from the datapath, level-sampled in IDLE.
REQ-006 Write  in  1: write request from the datapath, level-sampled in IDLE.
REQ-007 MARaddr  in  32: word address driven by the datapath MAR.
REQ-008 MDRdata  in  32: write data driven by the datapath MDR.
REQ-009 Mdatain  out  32: registered read data presented to the datapath MDR input.
REQ-010 MemDone  out  1: one-cycle completion pulse for a read or write.
REQ-011 MemBusy  out  1: high while a request is in progress.
REQ-012 BusErr  out  1: one-cycle out-of-range error pulse; tied to 0 when the range check is compiled out.

Function
REQ-013 FSM states: IDLE, WAIT, RESP.
REQ-014 In IDLE, the block accepts a request on a rising edge with Read=1 or Write=1; it captures MARaddr, MDRdata and the request type at that edge (E0).
REQ-015 If Read=1 and Write=1 at E0, the request is a read and the write is discarded.
REQ-016 With WAIT_STATES=W>0, the FSM goes IDLE->WAIT at E0 and loads a 4-bit counter with W-1; WAIT decrements the counter each cycle and moves to RESP on the edge where the counter is 0.
REQ-017 With WAIT_STATES=0, the FSM goes IDLE->RESP directly at E0.
REQ-018 MemDone is 1 for exactly the single cycle after edge E0+W (the RESP cycle); RESP always returns to IDLE on the next edge.
REQ-019 For a read, Mdatain is loaded with mem[addr] on the edge entering RESP and holds its value until the next read completes, including across writes and idle cycles.
REQ-020 For a write, mem[addr] is written with the captured data on the edge entering RESP; Mdatain is unchanged.
REQ-021 The index is the low DEPTH_LOG2 bits of the captured address; the upper bits wrap around unless the range check is compiled in.
REQ-022 MemBusy is 1 in WAIT and RESP and 0 in IDLE.
REQ-023 Read and Write are ignored in WAIT and RESP; there is no queuing.
REQ-024 A request still asserted when the FSM returns to IDLE is accepted as a new request, so a held Read produces back-to-back accesses.
REQ-025 A read of a location in the same cycle that it is written cannot occur, because the block serves one request at a time.

Reset
REQ-026 While Clear=0 at a rising edge: FSM -> IDLE, counter -> 0, Mdatain -> 32'h0, MemDone -> 0, MemBusy -> 0, BusErr -> 0.
REQ-027 Reset mid-operation abandons the request; a pending write that has not yet reached RESP is not committed.
REQ-028 Memory array contents are not cleared by reset.
REQ-029 A request asserted in the same cycle as Clear=0 is not accepted.

Configuration
REQ-030 Macro MEM_RANGECHK_EN defined: any captured address >= 2**DEPTH_LOG2 completes with normal timing, and BusErr pulses together with MemDone.
REQ-031 Under MEM_RANGECHK_EN, an out-of-range read loads Mdatain with 32'h0 and an out-of-range write leaves memory unchanged.
REQ-032 MEM_RANGECHK_EN undefined: no range check; addresses wrap per REQ-021 and BusErr is constant 0.

Verification
REQ-033 Write then read, W=2: Write=1, MARaddr=0x10, MDRdata=0x28918000 for one cycle; MemDone goes high 2 cycles after acceptance; then Read at 0x10 gives Mdatain=0x28918000 with MemDone high in the same cycle.
REQ-034 W=0: Read at 0x12 previously written with 0x14 gives MemDone and Mdatain=0x14 in the cycle immediately after acceptance.
REQ-035 Simultaneous Read=1 and Write=1 (MDRdata=0xFFFFFFFF) at an address holding 0x18 gives Mdatain=0x18, and memory remains 0x18.
REQ-036 Apply Clear=0 during WAIT of a write of 0xAA to 0x20 (old value 0x55): outputs go to 0 next edge, and a later read of 0x20 returns 0x55.
REQ-037 Read held high for 3 requests with W=1 gives MemDone pulses every 3 cycles and MemBusy low for exactly one cycle between them.
REQ-038 Address 0x200 with DEPTH_LOG2=9: with MEM_RANGECHK_EN, a read returns 0 and BusErr=1; without it, the read aliases to address 0x000.
